// File: rtl/riscv_ahb3lite_bus_arbiter_if.sv
// AHB3-Lite signal bundle: one instance each for the instruction side,
// the data side and the shared system bus of riscv_ahb3lite_bus_arbiter.
interface riscv_ahb3lite_bus_arbiter_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/riscv_ahb3lite_bus_arbiter.sv
// Shares one AHB3-Lite master port between the instruction and data masters, replaying a
// losing master's captured address phase. Define RISCV_AHB_ARB_RR_EN for round-robin arbitration.
module riscv_ahb3lite_bus_arbiter #(
    parameter int HADDR_SIZE   = 32,
    parameter int HDATA_SIZE   = 32,
    parameter int DAT_PRIORITY = 1
) (
    input  logic                         HRESETn,
    input  logic                         HCLK,
    riscv_ahb3lite_bus_arbiter_if.slave  ins,
    riscv_ahb3lite_bus_arbiter_if.slave  dat,
    riscv_ahb3lite_bus_arbiter_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {OWN_NONE, OWN_INS, OWN_DAT} owner_e;
    typedef enum logic       {GNT_INS, GNT_DAT}           gnt_e;

    typedef struct packed {
        logic [HADDR_SIZE-1:0] haddr;
        logic                  hwrite;
        logic [2:0]            hsize;
        logic [2:0]            hburst;
        logic [3:0]            hprot;
        logic [1:0]            htrans;
        logic                  hmastlock;
    } aphase_t;

    aphase_t live_ins, live_dat;
    aphase_t pend_ins, pend_dat;
    aphase_t issued;
    logic    pending_ins, pending_dat;
    gnt_e    gnt, winner, contend_winner;
    owner_e  downer;
    logic    ins_ready, dat_ready;
    logic    live_req_ins, live_req_dat;
    logic    req_ins, req_dat;
    logic    hold, issue, accept;
    logic    capture_ins, capture_dat;

    assign live_ins = {ins.HADDR, ins.HWRITE, ins.HSIZE, ins.HBURST, ins.HPROT, ins.HTRANS, ins.HMASTLOCK};
    assign live_dat = {dat.HADDR, dat.HWRITE, dat.HSIZE, dat.HBURST, dat.HPROT, dat.HTRANS, dat.HMASTLOCK};

    // A master stalls while its captured transfer waits; otherwise it follows the bus
    // only when it owns the current data phase.
    assign ins_ready = (downer == OWN_INS) ? bus.HREADY : ~pending_ins;
    assign dat_ready = (downer == OWN_DAT) ? bus.HREADY : ~pending_dat;

    assign live_req_ins = ins.HSEL & (ins.HTRANS == HTRANS_NONSEQ) & ins_ready;
    assign live_req_dat = dat.HSEL & (dat.HTRANS == HTRANS_NONSEQ) & dat_ready;
    assign req_ins      = pending_ins | live_req_ins;
    assign req_dat      = pending_dat | live_req_dat;

    // SEQ and BUSY both have HTRANS[0] set; bursts and locked sequences keep the grant.
    assign hold = (gnt == GNT_INS) ? (ins.HSEL & (ins.HTRANS[0] | ins.HMASTLOCK))
                                   : (dat.HSEL & (dat.HTRANS[0] | dat.HMASTLOCK));

`ifdef RISCV_AHB_ARB_RR_EN
    assign contend_winner = (gnt == GNT_INS) ? GNT_DAT : GNT_INS;
`else
    assign contend_winner = (DAT_PRIORITY != 0) ? GNT_DAT : GNT_INS;
`endif

    always_comb begin
        // NOTE: defaulting every always_comb target first keeps any path from inferring a latch.
        winner = gnt;
        if (hold)                winner = gnt;
        else if (req_ins && req_dat) winner = contend_winner;
        else if (req_dat)        winner = GNT_DAT;
        else if (req_ins)        winner = GNT_INS;
    end

    assign issue = hold | req_ins | req_dat;

    always_comb begin
        issued = live_ins;
        if (winner == GNT_INS) issued = pending_ins ? pend_ins : live_ins;
        else                   issued = pending_dat ? pend_dat : live_dat;
    end

    always_comb begin
        bus.HSEL      = 1'b0;
        bus.HADDR     = '0;
        bus.HWRITE    = 1'b0;
        bus.HSIZE     = 3'b000;
        bus.HBURST    = 3'b000;
        bus.HPROT     = 4'b0000;
        bus.HTRANS    = HTRANS_IDLE;
        bus.HMASTLOCK = 1'b0;
        if (HRESETn) begin
            bus.HSEL      = issue;
            bus.HADDR     = issued.haddr;
            bus.HWRITE    = issued.hwrite;
            bus.HSIZE     = issued.hsize;
            bus.HBURST    = issued.hburst;
            bus.HPROT     = issued.hprot;
            bus.HTRANS    = issue ? issued.htrans : HTRANS_IDLE;
            bus.HMASTLOCK = issue & issued.hmastlock;
        end
    end

    assign bus.HWDATA = (downer == OWN_DAT) ? dat.HWDATA : ins.HWDATA;

    assign ins.HRDATA = bus.HRDATA;
    assign dat.HRDATA = bus.HRDATA;
    assign ins.HREADY = ins_ready;
    assign dat.HREADY = dat_ready;
    assign ins.HRESP  = (downer == OWN_INS) ? bus.HRESP : 1'b0;
    assign dat.HRESP  = (downer == OWN_DAT) ? bus.HRESP : 1'b0;

    // A live NONSEQ the master believes accepted must be kept unless the bus took it this cycle.
    assign accept      = bus.HREADY & issue;
    assign capture_ins = live_req_ins & ~(accept & (winner == GNT_INS));
    assign capture_dat = live_req_dat & ~(accept & (winner == GNT_DAT));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pending_ins <= 1'b0;
            pending_dat <= 1'b0;
            pend_ins    <= '0;
            pend_dat    <= '0;
            gnt         <= GNT_INS;
            downer      <= OWN_NONE;
        end else begin
            if (capture_ins) begin
                pending_ins <= 1'b1;
                pend_ins    <= live_ins;
            end else if (accept && (winner == GNT_INS)) begin
                pending_ins <= 1'b0;
            end

            if (capture_dat) begin
                pending_dat <= 1'b1;
                pend_dat    <= live_dat;
            end else if (accept && (winner == GNT_DAT)) begin
                pending_dat <= 1'b0;
            end

            if (bus.HREADY) begin
                if (issue) begin
                    gnt <= winner;
                    if (issued.htrans[1]) downer <= (winner == GNT_DAT) ? OWN_DAT : OWN_INS;
                    else                  downer <= OWN_NONE;
                end else begin
                    downer <= OWN_NONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_ahb3lite_bus_arbiter.sv
// Directed bench for riscv_ahb3lite_bus_arbiter: single reads, contention, burst hold,
// error response, bus wait states, arbitration order and reset mid-sequence.
module tb_riscv_ahb3lite_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR8  = 3'b101;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    riscv_ahb3lite_bus_arbiter_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) ins_if (), dat_if (), bus_if ();

    riscv_ahb3lite_bus_arbiter #(
        .HADDR_SIZE  (AW),
        .HDATA_SIZE  (DW),
        .DAT_PRIORITY(1)
    ) dut (
        .HRESETn(HRESETn),
        .HCLK   (HCLK),
        .ins    (ins_if),
        .dat    (dat_if),
        .bus    (bus_if)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_ins(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                           input logic wr, input logic [2:0] burst);
        ins_if.HSEL      = sel;
        ins_if.HTRANS    = trans;
        ins_if.HADDR     = addr;
        ins_if.HWRITE    = wr;
        ins_if.HBURST    = burst;
        ins_if.HSIZE     = 3'b010;
        ins_if.HPROT     = 4'b0011;
        ins_if.HMASTLOCK = 1'b0;
    endtask

    task automatic drv_dat(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                           input logic wr, input logic [2:0] burst);
        dat_if.HSEL      = sel;
        dat_if.HTRANS    = trans;
        dat_if.HADDR     = addr;
        dat_if.HWRITE    = wr;
        dat_if.HBURST    = burst;
        dat_if.HSIZE     = 3'b010;
        dat_if.HPROT     = 4'b0011;
        dat_if.HMASTLOCK = 1'b0;
    endtask

    // Both masters request single reads; checks issued address and per-master ready.
    task automatic bb(input string tag, input logic [31:0] ia, input logic ion,
                      input logic [31:0] da, input logic don,
                      input logic [31:0] exp_addr, input logic exp_ir, input logic exp_dr);
        drv_ins(ion, ion ? NONSEQ : IDLE, ia, 1'b0, SINGLE);
        drv_dat(don, don ? NONSEQ : IDLE, da, 1'b0, SINGLE);
        settle();
        check({tag, "_haddr"}, bus_if.HADDR, exp_addr);
        check({tag, "_htrans"}, 32'(bus_if.HTRANS), 32'd2);
        check({tag, "_ins_hready"}, 32'(ins_if.HREADY), 32'(exp_ir));
        check({tag, "_dat_hready"}, 32'(dat_if.HREADY), 32'(exp_dr));
    endtask

    initial begin
        drv_ins(1'b1, NONSEQ, 32'h200, 1'b0, SINGLE);
        drv_dat(1'b0, IDLE, 32'h0, 1'b0, SINGLE);
        ins_if.HWDATA = '0;
        dat_if.HWDATA = '0;
        bus_if.HRDATA = '0;
        bus_if.HREADY = 1'b1;
        bus_if.HRESP  = 1'b0;
        #2;
        // Reset: outputs idle even with a live NONSEQ on the ins side
        check("rst_htrans", 32'(bus_if.HTRANS), 32'd0);
        check("rst_hsel", 32'(bus_if.HSEL), 32'd0);
        check("rst_haddr", bus_if.HADDR, 32'h0);
        check("rst_ins_hready", 32'(ins_if.HREADY), 32'd1);
        check("rst_dat_hready", 32'(dat_if.HREADY), 32'd1);
        check("rst_ins_hresp", 32'(ins_if.HRESP), 32'd0);
        check("rst_dat_hresp", 32'(dat_if.HRESP), 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // 1: ins-only single reads, zero added latency
        settle();
        check("t1_a_haddr", bus_if.HADDR, 32'h200);
        check("t1_a_htrans", 32'(bus_if.HTRANS), 32'd2);
        check("t1_a_hsel", 32'(bus_if.HSEL), 32'd1);
        tick();
        drv_ins(1'b1, NONSEQ, 32'h204, 1'b0, SINGLE);
        bus_if.HRDATA = 32'h1111_1111;
        bus_if.HREADY = 1'b0;
        settle();
        check("t1_b_ins_hready_low", 32'(ins_if.HREADY), 32'd0);
        bus_if.HREADY = 1'b1;
        settle();
        check("t1_b_ins_hready_high", 32'(ins_if.HREADY), 32'd1);
        check("t1_b_haddr", bus_if.HADDR, 32'h204);
        check("t1_b_ins_hrdata", ins_if.HRDATA, 32'h1111_1111);
        tick();
        drv_ins(1'b0, IDLE, 32'h204, 1'b0, SINGLE);
        settle();
        check("t1_c_htrans_idle", 32'(bus_if.HTRANS), 32'd0);
        check("t1_c_hsel", 32'(bus_if.HSEL), 32'd0);
        check("t1_c_haddr_park", bus_if.HADDR, 32'h204);
        tick();

        // 2: simultaneous NONSEQ, dat wins, ins replayed next cycle
        drv_ins(1'b1, NONSEQ, 32'h200, 1'b0, SINGLE);
        drv_dat(1'b1, NONSEQ, 32'h1000, 1'b1, SINGLE);
        settle();
        check("t2_d_haddr", bus_if.HADDR, 32'h1000);
        check("t2_d_hwrite", 32'(bus_if.HWRITE), 32'd1);
        tick();
        drv_ins(1'b0, IDLE, 32'h200, 1'b0, SINGLE);
        drv_dat(1'b0, IDLE, 32'h1000, 1'b0, SINGLE);
        dat_if.HWDATA = 32'hDEAD_BEEF;
        ins_if.HWDATA = 32'h5555_5555;
        settle();
        check("t2_e_haddr", bus_if.HADDR, 32'h200);
        check("t2_e_htrans", 32'(bus_if.HTRANS), 32'd2);
        check("t2_e_hwrite", 32'(bus_if.HWRITE), 32'd0);
        check("t2_e_hwdata", bus_if.HWDATA, 32'hDEAD_BEEF);
        check("t2_e_ins_hready", 32'(ins_if.HREADY), 32'd0);
        check("t2_e_dat_hready", 32'(dat_if.HREADY), 32'd1);
        tick();
        bus_if.HRDATA = 32'hCAFE_0200;
        settle();
        check("t2_f_ins_hready", 32'(ins_if.HREADY), 32'd1);
        check("t2_f_ins_hrdata", ins_if.HRDATA, 32'hCAFE_0200);
        check("t2_f_dat_hrdata", dat_if.HRDATA, 32'hCAFE_0200);
        check("t2_f_hwdata", bus_if.HWDATA, 32'h5555_5555);
        tick();

        // 3: INCR8 burst is never split; dat captured at beat 2, issued after last beat
        drv_ins(1'b1, NONSEQ, 32'h400, 1'b0, INCR8);
        settle();
        check("t3_first_haddr", bus_if.HADDR, 32'h400);
        tick();
        for (int k = 1; k < 8; k++) begin
            drv_ins(1'b1, SEQ, 32'h400 + 32'(4 * k), 1'b0, INCR8);
            if (k == 2) drv_dat(1'b1, NONSEQ, 32'h1000, 1'b0, SINGLE);
            else        drv_dat(1'b0, IDLE, 32'h1000, 1'b0, SINGLE);
            settle();
            check("t3_beat_haddr", bus_if.HADDR, 32'h400 + 32'(4 * k));
            check("t3_beat_htrans", 32'(bus_if.HTRANS), 32'd3);
            check("t3_beat_dat_hready", 32'(dat_if.HREADY), (k > 2) ? 32'd0 : 32'd1);
            tick();
        end
        drv_ins(1'b0, IDLE, 32'h41C, 1'b0, SINGLE);
        settle();
        check("t3_dat_haddr", bus_if.HADDR, 32'h1000);
        check("t3_dat_htrans", 32'(bus_if.HTRANS), 32'd2);
        check("t3_dat_hready_wait", 32'(dat_if.HREADY), 32'd0);
        tick();
        settle();
        check("t3_dat_hready_done", 32'(dat_if.HREADY), 32'd1);
        tick();

        // 4: dat write gets a two-cycle ERROR; pending ins read still issued
        drv_ins(1'b1, NONSEQ, 32'h200, 1'b0, SINGLE);
        drv_dat(1'b1, NONSEQ, 32'h1000, 1'b1, SINGLE);
        settle();
        check("t4_h_haddr", bus_if.HADDR, 32'h1000);
        tick();
        drv_ins(1'b0, IDLE, 32'h200, 1'b0, SINGLE);
        drv_dat(1'b0, IDLE, 32'h1000, 1'b0, SINGLE);
        dat_if.HWDATA = 32'h1234_5678;
        bus_if.HREADY = 1'b0;
        bus_if.HRESP  = 1'b1;
        settle();
        check("t4_i_dat_hresp", 32'(dat_if.HRESP), 32'd1);
        check("t4_i_ins_hresp", 32'(ins_if.HRESP), 32'd0);
        check("t4_i_dat_hready", 32'(dat_if.HREADY), 32'd0);
        check("t4_i_hwdata", bus_if.HWDATA, 32'h1234_5678);
        tick();
        bus_if.HREADY = 1'b1;
        settle();
        check("t4_j_dat_hresp", 32'(dat_if.HRESP), 32'd1);
        check("t4_j_ins_hresp", 32'(ins_if.HRESP), 32'd0);
        check("t4_j_dat_hready", 32'(dat_if.HREADY), 32'd1);
        check("t4_j_ins_hready", 32'(ins_if.HREADY), 32'd0);
        check("t4_j_haddr", bus_if.HADDR, 32'h200);
        check("t4_j_htrans", 32'(bus_if.HTRANS), 32'd2);
        tick();
        bus_if.HRESP = 1'b0;
        settle();
        check("t4_k_ins_hready", 32'(ins_if.HREADY), 32'd1);
        check("t4_k_ins_hresp", 32'(ins_if.HRESP), 32'd0);
        tick();

        // 5: bus wait states during dat data phase hold the captured ins transfer
        drv_ins(1'b1, NONSEQ, 32'h200, 1'b0, SINGLE);
        drv_dat(1'b1, NONSEQ, 32'h1000, 1'b0, SINGLE);
        settle();
        check("t5_l_haddr", bus_if.HADDR, 32'h1000);
        tick();
        drv_ins(1'b0, IDLE, 32'h200, 1'b0, SINGLE);
        drv_dat(1'b0, IDLE, 32'h1000, 1'b0, SINGLE);
        bus_if.HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            settle();
            check("t5_wait_ins_hready", 32'(ins_if.HREADY), 32'd0);
            check("t5_wait_dat_hready", 32'(dat_if.HREADY), 32'd0);
            tick();
        end
        bus_if.HREADY = 1'b1;
        settle();
        check("t5_m4_haddr", bus_if.HADDR, 32'h200);
        check("t5_m4_htrans", 32'(bus_if.HTRANS), 32'd2);
        check("t5_m4_ins_hready", 32'(ins_if.HREADY), 32'd0);
        check("t5_m4_dat_hready", 32'(dat_if.HREADY), 32'd1);
        tick();
        settle();
        check("t5_n_ins_hready", 32'(ins_if.HREADY), 32'd1);
        tick();

        // 6: back-to-back NONSEQ from both masters, then reset mid-sequence
`ifdef RISCV_AHB_ARB_RR_EN
        bb("t6_p1", 32'h200, 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 1'b1);
        tick();
        bb("t6_p2", 32'h204, 1'b1, 32'h1004, 1'b1, 32'h200, 1'b0, 1'b1);
        tick();
        bb("t6_p3", 32'h204, 1'b1, 32'h1008, 1'b1, 32'h1004, 1'b1, 1'b0);
        tick();
        bb("t6_p4", 32'h208, 1'b1, 32'h1008, 1'b1, 32'h204, 1'b0, 1'b1);
`else
        bb("t6_p1", 32'h200, 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 1'b1);
        tick();
        bb("t6_p2", 32'h204, 1'b1, 32'h1004, 1'b1, 32'h1004, 1'b0, 1'b1);
        tick();
        bb("t6_p3", 32'h204, 1'b1, 32'h1008, 1'b1, 32'h1008, 1'b0, 1'b1);
        tick();
        bb("t6_p4", 32'h204, 1'b1, 32'h100C, 1'b0, 32'h200, 1'b0, 1'b1);
`endif
        HRESETn = 1'b0;
        settle();
        check("t6_rst_htrans", 32'(bus_if.HTRANS), 32'd0);
        check("t6_rst_hsel", 32'(bus_if.HSEL), 32'd0);
        check("t6_rst_ins_hready", 32'(ins_if.HREADY), 32'd1);
        check("t6_rst_dat_hready", 32'(dat_if.HREADY), 32'd1);
        tick();
        HRESETn = 1'b1;
        drv_ins(1'b1, NONSEQ, 32'h300, 1'b0, SINGLE);
        drv_dat(1'b0, IDLE, 32'h0, 1'b0, SINGLE);
        settle();
        check("t6_post_haddr", bus_if.HADDR, 32'h300);
        check("t6_post_htrans", 32'(bus_if.HTRANS), 32'd2);
        tick();
        drv_ins(1'b0, IDLE, 32'h300, 1'b0, SINGLE);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
